// File: rtl/dmem_arbiter_if.sv
`default_nettype none
// ============================================================================
// dmem_arbiter_if : CPU, debug and memory-side bus bundle for dmem_arbiter
// Rev 1.0
// ============================================================================
interface dmem_arbiter_if #(
  parameter int AW = 5,
  parameter int DW = 32
);
  logic          cpu_req;
  logic          cpu_we;
  logic [AW-1:0] cpu_addr;
  logic [DW-1:0] cpu_wdata;
  logic [DW-1:0] cpu_rdata;
  logic          cpu_stall;

  logic          dbg_req;
  logic          dbg_we;
  logic [AW-1:0] dbg_addr;
  logic [DW-1:0] dbg_wdata;
  logic          dbg_ack;
  logic [DW-1:0] dbg_rdata;
  logic          dbg_rvalid;

  logic          mem_en;
  logic          mem_we;
  logic [AW-1:0] mem_addr;
  logic [DW-1:0] mem_wdata;
  logic [DW-1:0] mem_rdata;

  modport slave (
    input  cpu_req, cpu_we, cpu_addr, cpu_wdata,
    output cpu_rdata, cpu_stall,
    input  dbg_req, dbg_we, dbg_addr, dbg_wdata,
    output dbg_ack, dbg_rdata, dbg_rvalid,
    output mem_en, mem_we, mem_addr, mem_wdata,
    input  mem_rdata
  );

  modport master (
    output cpu_req, cpu_we, cpu_addr, cpu_wdata,
    input  cpu_rdata, cpu_stall,
    output dbg_req, dbg_we, dbg_addr, dbg_wdata,
    input  dbg_ack, dbg_rdata, dbg_rvalid,
    input  mem_en, mem_we, mem_addr, mem_wdata,
    output mem_rdata
  );
endinterface
`default_nettype wire

// File: rtl/dmem_arbiter.sv
`default_nettype none
// ============================================================================
// dmem_arbiter : CPU-priority arbiter for a single-port sync-read data memory
// Rev 1.0
// ============================================================================
module dmem_arbiter #(
  parameter int AW           = 5,
  parameter int DW           = 32,
  parameter int STARVE_LIMIT = 4
) (
  input  logic          clk,
  input  logic          resetn,
  dmem_arbiter_if.slave bus
);
  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    CPU_RD = 2'd1,
    DBG_RD = 2'd2
  } state_t;

  localparam logic [3:0]    c_starve_limit = 4'(STARVE_LIMIT);
  localparam logic [3:0]    c_starve_max   = 4'hF;
  localparam logic [AW-1:0] c_addr_zero    = {AW{1'b0}};
  localparam logic [DW-1:0] c_data_zero    = {DW{1'b0}};

  state_t     r_state;
  state_t     w_state_nxt;
  logic [3:0] r_starve_cnt;
  logic [3:0] w_starve_nxt;
  logic       w_grant_dbg;
  logic       w_grant_cpu;

  assign w_grant_dbg = resetn && (r_state == IDLE) && bus.dbg_req &&
                       (!bus.cpu_req || (r_starve_cnt >= c_starve_limit));
  assign w_grant_cpu = resetn && (r_state == IDLE) && bus.cpu_req && !w_grant_dbg;

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      r_state      <= IDLE;
      r_starve_cnt <= 4'd0;
    end else begin
      r_state      <= w_state_nxt;
      r_starve_cnt <= w_starve_nxt;
    end
  end

  always_comb begin
    w_starve_nxt = r_starve_cnt;
    if (w_grant_dbg)
      w_starve_nxt = 4'd0;
    else if (bus.dbg_req && (r_starve_cnt != c_starve_max))
      w_starve_nxt = r_starve_cnt + 4'd1;
  end

  // Everything is gated by resetn so that outputs read 0 for the whole reset
  // window even while the requesters keep their strobes up.
  always_comb begin
    w_state_nxt    = r_state;
    bus.cpu_rdata  = c_data_zero;
    bus.cpu_stall  = 1'b0;
    bus.dbg_ack    = 1'b0;
    bus.dbg_rdata  = c_data_zero;
    bus.dbg_rvalid = 1'b0;
    bus.mem_en     = 1'b0;
    bus.mem_we     = 1'b0;
    bus.mem_addr   = c_addr_zero;
    bus.mem_wdata  = c_data_zero;
    if (resetn) begin
      case (r_state)
        IDLE: begin
          if (w_grant_dbg) begin
            bus.mem_en    = 1'b1;
            bus.mem_we    = bus.dbg_we;
            bus.mem_addr  = bus.dbg_addr;
            bus.mem_wdata = bus.dbg_wdata;
            bus.dbg_ack   = 1'b1;
            bus.cpu_stall = bus.cpu_req;
            if (!bus.dbg_we)
              w_state_nxt = DBG_RD;
          end else if (w_grant_cpu) begin
            bus.mem_en    = 1'b1;
            bus.mem_we    = bus.cpu_we;
            bus.mem_addr  = bus.cpu_addr;
            bus.mem_wdata = bus.cpu_wdata;
            // Stores retire in the issue cycle; loads wait for the sync read.
            if (!bus.cpu_we) begin
              bus.cpu_stall = 1'b1;
              w_state_nxt   = CPU_RD;
            end
          end
        end
        CPU_RD: begin
          bus.cpu_rdata = bus.mem_rdata;
          w_state_nxt   = IDLE;
        end
        DBG_RD: begin
          bus.dbg_rvalid = 1'b1;
          bus.dbg_rdata  = bus.mem_rdata;
          bus.cpu_stall  = bus.cpu_req;
          w_state_nxt    = IDLE;
        end
        default: w_state_nxt = IDLE;
      endcase
    end
  end
endmodule
`default_nettype wire
